// File: rtl/bias_relu_serializer.sv
// Purpose : takes one M x N fixed-point result matrix per handshake, adds a per-column
//           bias, applies a saturating ReLU (or a plain clamp) and streams the frame out
//           one element per beat.
// Latency : accept at cycle T -> LOAD at T+1 -> first beat (k=0) at T+2. A frame takes
//           M*N+2 cycles when out_ready stays high.
// Backpressure: the input side is refused (in_ready=0) from the accept until the last
//           beat transfers. Output beats are held stable for as long as out_ready is low.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset (discards any held frame)
//   in_valid/in_ready   input handshake for in_matrix (row-major, k=i*N+j) and bias (per column)
//   out_valid/out_ready output handshake for out_data, out_index (k), out_last (k=M*N-1)
//   busy                high while a frame is held (LOAD or STREAM)
module bias_relu_serializer #(
    parameter int M       = 2,
    parameter int N       = 2,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [M*N*DATA_W-1:0]                     in_matrix,
    input  logic [N*DATA_W-1:0]                       bias,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DATA_W-1:0]                         out_data,
    output logic [((M*N > 1) ? $clog2(M*N) : 1)-1:0]  out_index,
    output logic                                      out_last,
    output logic                                      busy
);

    localparam int NE    = M * N;
    localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;

    localparam logic [IDX_W-1:0]  LAST_K  = IDX_W'(NE - 1);
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // FRAC_W only documents the Q format; the arithmetic never shifts. A format with no
    // integer bits left is almost certainly a mis-parameterised instance.
    if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac
        $error("bias_relu_serializer: FRAC_W must lie in [0, DATA_W-1]");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [IDX_W-1:0]    r_out_index;
    logic                r_out_last;
    logic                r_busy;
    logic [IDX_W-1:0]    r_k;

    // Frame as captured at the accept edge, and the activated frame written in LOAD.
    logic [NE*DATA_W-1:0] r_mat;
    logic [N*DATA_W-1:0]  r_bias;
    logic [DATA_W-1:0]    r_buf [NE];

    logic [DATA_W-1:0]    w_act [NE];
    logic [IDX_W-1:0]     w_k_next;
    logic                 w_accept;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

    assign w_accept  = in_valid && r_in_ready;
    assign w_k_next  = r_k + IDX_W'(1);

    // Sum in DATA_W+1 bits cannot overflow; the top two bits disagree exactly when the
    // true sum is outside the DATA_W range, and the top bit then gives the rail.
    function automatic logic [DATA_W-1:0] f_activate(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [DATA_W:0]   s;
        logic [DATA_W-1:0] sat;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            sat = s[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sat = s[DATA_W-1:0];
        end
        if (RELU_EN && sat[DATA_W-1]) begin
            f_activate = '0;
        end else begin
            f_activate = sat;
        end
    endfunction

    always_comb begin
        for (int k = 0; k < NE; k++) begin
            w_act[k] = f_activate(r_mat[k*DATA_W +: DATA_W], r_bias[(k % N)*DATA_W +: DATA_W]);
        end
    end

    // Datapath registers carry no reset: they are only read after a fresh accept/LOAD.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mat  <= in_matrix;
            r_bias <= bias;
        end
        if (r_state == S_LOAD) begin
            for (int k = 0; k < NE; k++) begin
                r_buf[k] <= w_act[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_k         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                // The buffer is written on this edge, so beat 0 comes straight from the
                // activation logic rather than from the buffer.
                S_LOAD: begin
                    r_state     <= S_STREAM;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_act[0];
                    r_out_index <= '0;
                    r_out_last  <= (NE == 1);
                    r_k         <= '0;
                end

                // out_valid is always high here, so out_ready alone marks a transfer.
                S_STREAM: begin
                    if (out_ready) begin
                        if (r_k == LAST_K) begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_index <= '0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_k         <= '0;
                        end else begin
                            r_k         <= w_k_next;
                            r_out_data  <= r_buf[w_k_next];
                            r_out_index <= w_k_next;
                            r_out_last  <= (w_k_next == LAST_K);
                        end
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_out_index <= '0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_k         <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_relu_serializer.sv
module tb_bias_relu_serializer;

    localparam int DW = 16;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [63:0]   in_matrix = '0;
    logic [31:0]   bias = '0;

    logic          in_ready_r, out_valid_r, out_last_r, busy_r;
    logic [15:0]   out_data_r;
    logic [1:0]    out_index_r;
    logic          in_ready_l, out_valid_l, out_last_l, busy_l;
    logic [15:0]   out_data_l;
    logic [1:0]    out_index_l;

    bias_relu_serializer #(.M(2), .N(2), .DATA_W(16), .FRAC_W(8), .RELU_EN(1'b1)) u_dut_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_matrix(in_matrix), .bias(bias), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_index(out_index_r), .out_last(out_last_r), .busy(busy_r)
    );

    bias_relu_serializer #(.M(2), .N(2), .DATA_W(16), .FRAC_W(8), .RELU_EN(1'b0)) u_dut_lin (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_matrix(in_matrix), .bias(bias), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .out_index(out_index_l), .out_last(out_last_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: exact integer sum, clamp to 16-bit signed, optional ReLU.
    function automatic logic [15:0] m_act(input logic [15:0] a, input logic [15:0] b, input bit relu);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    // Timeline model: idle until a frame is offered, one dead cycle, then one element per
    // consumer acceptance, back to idle after the fourth.
    int          m_state = 0;   // 0 idle, 1 load, 2 streaming
    int          m_k = 0;
    bit          m_live = 1'b0;
    logic [15:0] fr_r [NE];
    logic [15:0] fr_l [NE];

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_k     = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            if (m_state == 0) begin
                if (in_valid) begin
                    for (int k = 0; k < NE; k++) begin
                        fr_r[k] = m_act(in_matrix[k*16 +: 16], bias[(k % 2)*16 +: 16], 1'b1);
                        fr_l[k] = m_act(in_matrix[k*16 +: 16], bias[(k % 2)*16 +: 16], 1'b0);
                    end
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                m_state = 2;
                m_k     = 0;
            end else if (out_ready) begin
                if (m_k == NE - 1) m_state = 0;
                else               m_k = m_k + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            logic        e_str;
            logic [15:0] e_r, e_l;
            e_str = (m_state == 2);
            e_r   = e_str ? fr_r[m_k] : 16'h0;
            e_l   = e_str ? fr_l[m_k] : 16'h0;
            chk("in_ready",   {31'b0, in_ready_r},  {31'b0, m_state == 0});
            chk("busy",       {31'b0, busy_r},      {31'b0, m_state != 0});
            chk("out_valid",  {31'b0, out_valid_r}, {31'b0, e_str});
            chk("out_data",   {16'b0, out_data_r},  {16'b0, e_r});
            chk("out_index",  {30'b0, out_index_r}, e_str ? 32'(m_k) : 32'd0);
            chk("out_last",   {31'b0, out_last_r},  {31'b0, e_str && m_k == NE - 1});
            chk("lin_valid",  {31'b0, out_valid_l}, {31'b0, e_str});
            chk("lin_data",   {16'b0, out_data_l},  {16'b0, e_l});
            chk("lin_ready",  {31'b0, in_ready_l},  {31'b0, m_state == 0});
        end
    end

    // out_ready patterns: 0 always high, 1 repeating 1,0,0,1, 2 random.
    int rdy_mode = 0;
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            cyc++;
        end
    end

    task automatic send(input logic [63:0] mat, input logic [31:0] b);
        int guard;
        in_matrix = mat;
        bias      = b;
        in_valid  = 1'b1;
        guard     = 0;
        while (!in_ready_r && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", guard);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_matrix = {$urandom, $urandom};
        bias      = $urandom;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy_r || busy_l) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", guard);
        end
    endtask

    function automatic logic [15:0] rnd_el();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'h7000 | 16'($urandom_range(0, 16'h0FFF));
            2:       return 16'h8000 | 16'($urandom_range(0, 16'h0FFF));
            default: return 16'($urandom_range(0, 16'h03FF));
        endcase
    endfunction

    localparam logic [63:0] SPEC_MAT  = {16'h0300, 16'h0080, 16'hFE00, 16'h0100};
    localparam logic [31:0] SPEC_BIAS = {16'h0100, 16'h0040};

    initial begin
        logic [15:0] lit_r [NE];
        logic [15:0] lit_l [NE];
        lit_r = '{16'h0140, 16'h0000, 16'h00C0, 16'h0400};
        lit_l = '{16'h0140, 16'hFF00, 16'h00C0, 16'h0400};

        // Pin the reference arithmetic against hand-computed values.
        chk("pin_add",     {16'b0, m_act(16'h0100, 16'h0040, 1'b1)}, 32'h0140);
        chk("pin_relu",    {16'b0, m_act(16'hFE00, 16'h0100, 1'b1)}, 32'h0000);
        chk("pin_sat_hi",  {16'b0, m_act(16'h7F00, 16'h0200, 1'b1)}, 32'h7FFF);
        chk("pin_sat_lo",  {16'b0, m_act(16'h8100, 16'hFE00, 1'b0)}, 32'h8000);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  {31'b0, in_ready_r},  32'd1);
        chk("rst_out_valid", {31'b0, out_valid_r}, 32'd0);
        chk("rst_busy",      {31'b0, busy_r},      32'd0);
        @(posedge clk);
        #1;

        // Basic frame, out_ready high: beats at T+2..T+5, in_ready back at T+6.
        rdy_mode = 0;
        send(SPEC_MAT, SPEC_BIAS);
        @(negedge clk);
        chk("lit_load_valid", {31'b0, out_valid_r}, 32'd0);
        for (int i = 0; i < NE; i++) begin
            @(negedge clk);
            chk("lit_beat_relu", {16'b0, out_data_r},  {16'b0, lit_r[i]});
            chk("lit_beat_lin",  {16'b0, out_data_l},  {16'b0, lit_l[i]});
            chk("lit_index",     {30'b0, out_index_r}, 32'(i));
            chk("lit_last",      {31'b0, out_last_r},  (i == NE - 1) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("lit_ready_back", {31'b0, in_ready_r},  32'd1);
        chk("lit_valid_drop", {31'b0, out_valid_r}, 32'd0);
        @(posedge clk);
        #1;

        // Saturation on both rails.
        send({16'h0000, 16'h0000, 16'h8100, 16'h7F00}, {16'hFE00, 16'h0200});
        @(negedge clk);
        @(negedge clk);
        chk("lit_sat_hi_relu", {16'b0, out_data_r}, 32'h7FFF);
        chk("lit_sat_hi_lin",  {16'b0, out_data_l}, 32'h7FFF);
        @(negedge clk);
        chk("lit_sat_lo_relu", {16'b0, out_data_r}, 32'h0000);
        chk("lit_sat_lo_lin",  {16'b0, out_data_l}, 32'h8000);
        @(posedge clk);
        #1;
        wait_idle();

        // Stalls 1,0,0,1 pattern.
        rdy_mode = 1;
        send(SPEC_MAT, SPEC_BIAS);
        wait_idle();

        // in_valid held high with changing data: only idle-time offers are taken.
        rdy_mode = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_matrix = {rnd_el(), rnd_el(), rnd_el(), rnd_el()};
            bias      = {rnd_el(), rnd_el()};
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset after the second beat transfers.
        send(SPEC_MAT, SPEC_BIAS);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'b0, out_valid_r}, 32'd0);
        chk("rst_mid_ready", {31'b0, in_ready_r},  32'd1);
        @(posedge clk);
        #1;
        send({rnd_el(), rnd_el(), rnd_el(), rnd_el()}, {rnd_el(), rnd_el()});
        wait_idle();

        // Randomised frames with mixed backpressure and idle gaps.
        for (int f = 0; f < 40; f++) begin
            rdy_mode = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send({rnd_el(), rnd_el(), rnd_el(), rnd_el()}, {rnd_el(), rnd_el()});
        end
        rdy_mode = 0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
